// File: rtl/ring_distributor.sv
// Round-robin distributor: one valid/ready input stream fanned out to PORTS
// registered one-entry output slots, each accepted word going to exactly one port.
module ring_distributor #(
   parameter int PORTS = 4,
   parameter int WIDTH = 8
) (
   input  logic                   i_clock,
   input  logic                   i_aresetn,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic [PORTS*WIDTH-1:0] o_data,
   output logic [PORTS-1:0]       o_valid,
   input  logic [PORTS-1:0]       i_ready
);

   localparam int PW = $clog2(PORTS);

   logic [PORTS-1:0] slot_valid_q, slot_valid_d;
   logic [WIDTH-1:0] slot_data_q [PORTS];
   logic [PW-1:0]    last_grant_q, last_grant_d;
   logic [PW-1:0]    grant;
   logic [PW-1:0]    cand;
   logic [PORTS-1:0] free;
   logic [PORTS-1:0] load;
   logic             take;

   assign free    = ~slot_valid_q | i_ready;
   assign o_ready = |free;
   assign take    = i_valid & o_ready;
   assign o_valid = slot_valid_q;

   // Walk the ring backwards so the earliest free port after last_grant wins;
   // offset PORTS wraps to last_grant itself and is the lowest priority.
   always_comb begin
      grant = last_grant_q;
      cand  = last_grant_q;
      for (int k = PORTS; k >= 1; k--) begin
         cand = last_grant_q + PW'(k);
         if (free[cand]) grant = cand;
      end
   end

   assign load         = take ? (PORTS'(1) << grant) : '0;
   assign slot_valid_d = load | (slot_valid_q & ~i_ready);
   assign last_grant_d = take ? grant : last_grant_q;

   always_ff @(posedge i_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         slot_valid_q <= '0;
         last_grant_q <= PW'(PORTS - 1);
      end else begin
         slot_valid_q <= slot_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_slot
         // Data only moves on a load, so a stalled slot stays stable.
         always_ff @(posedge i_clock or negedge i_aresetn) begin
            if (!i_aresetn)
               slot_data_q[gi] <= '0;
            else if (load[gi])
               slot_data_q[gi] <= i_data;
         end
         assign o_data[gi*WIDTH +: WIDTH] = slot_data_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_ring_distributor.sv
// Table-driven bench for ring_distributor (PORTS=4, WIDTH=8) with hand-written
// reset sequences.
module tb_ring_distributor;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] o_data;
   logic [3:0]  o_valid;
   logic [3:0]  i_ready = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   ring_distributor #(.PORTS(4), .WIDTH(8)) dut (
      .i_clock   (clk),
      .i_aresetn (aresetn),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  din;
      logic [3:0]  rdy;
      logic        exp_rdy;
      logic [3:0]  exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      aresetn = 1'b0;
      i_valid = 1'b0;
      i_ready = '0;
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic apply(input int idx, input vec_t v);
      if (v.rst) do_reset();
      @(negedge clk);
      i_valid = v.vld;
      i_data  = v.din;
      i_ready = v.rdy;
      #1;
      chk($sformatf("v%0d o_ready", idx), {31'b0, o_ready}, {31'b0, v.exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d o_valid", idx), {28'b0, o_valid}, {28'b0, v.exp_valid});
      chk($sformatf("v%0d o_data", idx), o_data, v.exp_data);
      $display("vec %0d: vld=%b din=%h rdy=%b -> o_valid=%b o_data=%h", idx, v.vld, v.din, v.rdy, o_valid, o_data);
   endtask

   initial begin
      // First word after power-on reset
      vecs.push_back('{0, 1, 8'h5A, 4'h0, 1, 4'b0001, 32'h0000005A});
      // Full throughput, all consumers ready
      vecs.push_back('{1, 1, 8'h10, 4'hF, 1, 4'b0001, 32'h00000010});
      vecs.push_back('{0, 1, 8'h11, 4'hF, 1, 4'b0010, 32'h00001110});
      vecs.push_back('{0, 1, 8'h12, 4'hF, 1, 4'b0100, 32'h00121110});
      vecs.push_back('{0, 1, 8'h13, 4'hF, 1, 4'b1000, 32'h13121110});
      vecs.push_back('{0, 1, 8'h14, 4'hF, 1, 4'b0001, 32'h13121114});
      vecs.push_back('{0, 1, 8'h15, 4'hF, 1, 4'b0010, 32'h13121514});
      vecs.push_back('{0, 1, 8'h16, 4'hF, 1, 4'b0100, 32'h13161514});
      vecs.push_back('{0, 1, 8'h17, 4'hF, 1, 4'b1000, 32'h17161514});
      vecs.push_back('{0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h17161514});
      // Skip a stalled port (port 1 never ready)
      vecs.push_back('{1, 1, 8'h20, 4'b1101, 1, 4'b0001, 32'h00000020});
      vecs.push_back('{0, 1, 8'h21, 4'b1101, 1, 4'b0010, 32'h00002120});
      vecs.push_back('{0, 1, 8'h22, 4'b1101, 1, 4'b0110, 32'h00222120});
      vecs.push_back('{0, 1, 8'h23, 4'b1101, 1, 4'b1010, 32'h23222120});
      vecs.push_back('{0, 1, 8'h24, 4'b1101, 1, 4'b0011, 32'h23222124});
      vecs.push_back('{0, 1, 8'h25, 4'b1101, 1, 4'b0110, 32'h23252124});
      // Fill and stall, then same-port drain+reload on port 2
      vecs.push_back('{1, 1, 8'hA0, 4'h0, 1, 4'b0001, 32'h000000A0});
      vecs.push_back('{0, 1, 8'hA1, 4'h0, 1, 4'b0011, 32'h0000A1A0});
      vecs.push_back('{0, 1, 8'hA2, 4'h0, 1, 4'b0111, 32'h00A2A1A0});
      vecs.push_back('{0, 1, 8'hA3, 4'h0, 1, 4'b1111, 32'hA3A2A1A0});
      vecs.push_back('{0, 1, 8'hA4, 4'h0, 0, 4'b1111, 32'hA3A2A1A0});
      vecs.push_back('{0, 1, 8'hA4, 4'b0100, 1, 4'b1111, 32'hA3A4A1A0});
      vecs.push_back('{0, 0, 8'h00, 4'h0, 0, 4'b1111, 32'hA3A4A1A0});
      // Hold stability: port 3 keeps 0xC3 while streaming continues
      vecs.push_back('{1, 1, 8'hC0, 4'b0111, 1, 4'b0001, 32'h000000C0});
      vecs.push_back('{0, 1, 8'hC1, 4'b0111, 1, 4'b0010, 32'h0000C1C0});
      vecs.push_back('{0, 1, 8'hC2, 4'b0111, 1, 4'b0100, 32'h00C2C1C0});
      vecs.push_back('{0, 1, 8'hC3, 4'b0111, 1, 4'b1000, 32'hC3C2C1C0});
      vecs.push_back('{0, 1, 8'hC4, 4'b0111, 1, 4'b1001, 32'hC3C2C1C4});
      vecs.push_back('{0, 1, 8'hC5, 4'b0111, 1, 4'b1010, 32'hC3C2C5C4});
      vecs.push_back('{0, 1, 8'hC6, 4'b0111, 1, 4'b1100, 32'hC3C6C5C4});
      vecs.push_back('{0, 1, 8'hC7, 4'b0111, 1, 4'b1001, 32'hC3C6C5C7});
      vecs.push_back('{0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hC3C6C5C7});
      // Fill all slots ahead of the mid-operation reset
      vecs.push_back('{1, 1, 8'hB0, 4'h0, 1, 4'b0001, 32'h000000B0});
      vecs.push_back('{0, 1, 8'hB1, 4'h0, 1, 4'b0011, 32'h0000B1B0});
      vecs.push_back('{0, 1, 8'hB2, 4'h0, 1, 4'b0111, 32'h00B2B1B0});
      vecs.push_back('{0, 1, 8'hB3, 4'h0, 1, 4'b1111, 32'hB3B2B1B0});

      // Power-on reset with random inputs
      aresetn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         i_valid = 1'($urandom);
         i_data  = 8'($urandom);
         i_ready = 4'($urandom);
         #1;
         chk($sformatf("reset%0d o_valid", c), {28'b0, o_valid}, 32'h0);
         chk($sformatf("reset%0d o_data", c), o_data, 32'h0);
         $display("reset cycle %0d: o_valid=%b o_data=%h", c, o_valid, o_data);
      end
      @(negedge clk);
      aresetn = 1'b1;
      i_valid = 1'b0;
      i_ready = '0;
      #1;
      chk("release o_ready", {31'b0, o_ready}, 32'h1);
      $display("reset release: o_ready=%b", o_ready);

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // Mid-operation reset with every slot full: outputs drop without a clock edge
      @(negedge clk);
      i_valid = 1'b0;
      i_ready = '0;
      #2;
      aresetn = 1'b0;
      #1;
      chk("midrst o_valid", {28'b0, o_valid}, 32'h0);
      chk("midrst o_data", o_data, 32'h0);
      chk("midrst o_ready", {31'b0, o_ready}, 32'h1);
      $display("mid-op reset: o_valid=%b o_data=%h o_ready=%b", o_valid, o_data, o_ready);
      @(negedge clk);
      aresetn = 1'b1;
      apply(vecs.size(), '{0, 1, 8'h77, 4'h0, 1, 4'b0001, 32'h00000077});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ring_distributor.md
# ring_distributor

Round-robin distributor: one valid/ready input stream is fanned out to PORTS output streams, and each accepted word goes to exactly one output port. It is the counterpart of the ring arbiter, which merges many queues into one. This block splits one producer across many consumers, for example to spread work over parallel lanes. Each output port has a one-entry registered slot, so the block sustains one word per cycle whenever at least one port can take it.

## Interface
- PORTS, default 4: number of output ports; power of two, at least 2.
- WIDTH, default 8: data word width in bits.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_aresetn  in  1  reset, asynchronous, active-low.
- i_data  in  WIDTH  input word.
- i_valid  in  1  input word is present.
- o_ready  out  1  the block accepts i_data this cycle.
- o_data  out  PORTS*WIDTH  output words; port p occupies bits [p*WIDTH +: WIDTH].
- o_valid  out  PORTS  slot p holds a word for consumer p.
- i_ready  in  PORTS  consumer p takes its word this cycle.

## Operation
- Per-port state: slot_valid[p] and slot_data[p]. o_valid = slot_valid; the o_data slice for port p = slot_data[p].
- Free test: slot p is free this cycle if !slot_valid[p] || i_ready[p].
- o_ready is the OR of the free bits over all ports.
- Round-robin pointer: last_grant, $clog2(PORTS) bits, reset to PORTS-1.
- Search order: last_grant+1, last_grant+2, … with modulo-PORTS wrap, ending at last_grant itself. The grant is the first free port in that order.
- Input transfer: occurs when i_valid && o_ready. Then slot_data[grant] <= i_data, slot_valid[grant] <= 1 and last_grant <= grant.
- No transfer: last_grant holds.
- Output transfer on port p: occurs when o_valid[p] && i_ready[p]. If port p is not loaded the same cycle, slot_valid[p] <= 0.
- Drain and load on the same port in one cycle: slot_data takes the new word and slot_valid stays 1.
- slot_data[p] changes only on a load; it holds its last value while the slot is empty.
- i_ready[p] while o_valid[p]=0 has no effect.
- If all consumers are continuously ready, the port sequence is 0, 1, …, PORTS-1, 0, ….
- A port that is full and not ready is skipped. It is not waited for.
- Outputs obey the valid/ready rule: while o_valid[p] && !i_ready[p], the o_data slice p and o_valid[p] stay stable.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - o_valid = 0 and o_data = 0.
  - last_grant = PORTS-1.
  - o_ready = 1 from the first cycle after reset, since all slots are empty.
- Latency: a word accepted at edge n appears on o_valid/o_data after edge n. That is one cycle, with no bypass path.
- Throughput: one word per cycle while at least one slot is free.
- Combinational paths:
  - o_ready depends only on slot_valid and i_ready.
  - There is no path from i_valid or i_data to any output.
  - o_valid and o_data are registered.
- All slots full and i_ready = 0: o_ready = 0. The block holds its state and the upstream holds its word.
- Pointer wrap: after last_grant = PORTS-1, the search restarts at port 0.
- Reset mid-operation: all held words are discarded, o_valid drops immediately, and the pointer returns to PORTS-1, so the next grant is port 0.
- Arithmetic: pointer add and compare are modulo PORTS, with no extra width.

## Test plan
- Reset: hold i_aresetn=0 with random inputs. Required: o_valid=0, o_data=0, o_ready=1 on release. The first word 0x5A goes to port 0, and o_valid=4'b0001 after one edge.
- Full throughput: i_ready=4'hF; stream 0x10..0x17 back-to-back.
  - Each word appears on port k mod 4 exactly one cycle after acceptance.
  - o_valid is one-hot, rotating 0001, 0010, 0100, 1000, 0001, …
  - o_ready stays 1 and no word is lost.
- Fill and stall, then same-port reload:
  - Set i_ready=0 and send 0xA0..0xA3. Required: ports 0..3 hold them and o_ready=0 after the 4th accept.
  - Present 0xA4 and it is held. Pulse i_ready[2] for one cycle.
  - Required: 0xA2 is consumed, 0xA4 loads port 2 on the same edge, o_valid[2] stays 1, and o_ready returns to 0.
- Skip a stalled port: i_ready=4'b1101; stream 6 words w0..w5.
  - Required port order: 0, 1, 2, 3, 0, 2. Port 1 keeps w1 with o_valid[1]=1.
- Hold stability: i_ready[3]=0 while port 3 holds 0xC3, and keep streaming. Required: the port 3 slice = 0xC3 with o_valid[3]=1 stable for every cycle until i_ready[3] rises.
- Reset mid-operation: assert i_aresetn with all slots full. Required: o_valid=0 asynchronously and o_data=0. After release, the next accepted word goes to port 0.
